// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter with address/control mux and data-phase write-data mux.
// Define ARB_FIXED_PRIORITY_EN for fixed M0 priority (no MAX_HOLD rotation, hold_cnt tied to 0).
module ahb_master_arbiter #(
  parameter int MAX_HOLD       = 8,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_hbusreq,
  input  logic [31:0] m0_haddr,
  input  logic [1:0]  m0_htrans,
  input  logic [2:0]  m0_hsize,
  input  logic [2:0]  m0_hburst,
  input  logic        m0_hwrite,
  input  logic [31:0] m0_hwdata,
  output logic        m0_hgrant,
  input  logic        m1_hbusreq,
  input  logic [31:0] m1_haddr,
  input  logic [1:0]  m1_htrans,
  input  logic [2:0]  m1_hsize,
  input  logic [2:0]  m1_hburst,
  input  logic        m1_hwrite,
  input  logic [31:0] m1_hwdata,
  output logic        m1_hgrant,
  input  logic        s_hready,
  output logic [31:0] s_haddr,
  output logic [1:0]  s_htrans,
  output logic [2:0]  s_hsize,
  output logic [2:0]  s_hburst,
  output logic        s_hwrite,
  output logic [31:0] s_hwdata,
  output logic        hmaster,
  output logic        hmaster_d
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam owner_e DEF_OWNER = owner_e'(DEFAULT_MASTER[0]);

  owner_e     addr_own_q, addr_own_d;
  owner_e     data_own_q;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       m0_grant_q, m1_grant_q;
  logic       own_req;

`ifdef ARB_FIXED_PRIORITY_EN
  // M0 always wins; M1 only gets the bus while M0 is silent.
  always_comb begin
    addr_own_d = addr_own_q;
    hold_cnt_d = 8'd0;
    if (m0_hbusreq)      addr_own_d = OWN_M0;
    else if (m1_hbusreq) addr_own_d = OWN_M1;
    else                 addr_own_d = DEF_OWNER;
  end
`else
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic   oth_req;
  owner_e other_own;

  always_comb begin
    other_own  = (addr_own_q == OWN_M1) ? OWN_M0 : OWN_M1;
    oth_req    = (addr_own_q == OWN_M1) ? m0_hbusreq : m1_hbusreq;
    addr_own_d = addr_own_q;
    hold_cnt_d = 8'd0;
    if (!m0_hbusreq && !m1_hbusreq) begin
      addr_own_d = DEF_OWNER;
    end else if (own_req && oth_req) begin
      // Contention: owner keeps the bus for MAX_HOLD granted cycles, then rotates.
      if (hold_cnt_q == HOLD_LAST) begin
        addr_own_d = other_own;
      end else begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end
    end else if (!own_req) begin
      addr_own_d = other_own;
    end
  end
`endif

  assign own_req = (addr_own_q == OWN_M1) ? m1_hbusreq : m0_hbusreq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_own_q <= DEF_OWNER;
      data_own_q <= DEF_OWNER;
      hold_cnt_q <= 8'd0;
      m0_grant_q <= (DEF_OWNER == OWN_M0);
      m1_grant_q <= (DEF_OWNER == OWN_M1);
    end else if (s_hready) begin
      addr_own_q <= addr_own_d;
      data_own_q <= addr_own_q;
      hold_cnt_q <= hold_cnt_d;
      m0_grant_q <= (addr_own_d == OWN_M0);
      m1_grant_q <= (addr_own_d == OWN_M1);
    end
  end

  assign m0_hgrant = m0_grant_q;
  assign m1_hgrant = m1_grant_q;
  assign hmaster   = addr_own_q;
  assign hmaster_d = data_own_q;

  always_comb begin
    if (addr_own_q == OWN_M1) begin
      s_haddr  = m1_haddr;
      s_htrans = m1_htrans;
      s_hsize  = m1_hsize;
      s_hburst = m1_hburst;
      s_hwrite = m1_hwrite;
    end else begin
      s_haddr  = m0_haddr;
      s_htrans = m0_htrans;
      s_hsize  = m0_hsize;
      s_hburst = m0_hburst;
      s_hwrite = m0_hwrite;
    end
    // Masters drive NONSEQ unconditionally, so an owner without a request must look IDLE.
    if (!own_req) s_htrans = 2'b00;
  end

  assign s_hwdata = (data_own_q == OWN_M1) ? m1_hwdata : m0_hwdata;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_ahb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_hbusreq, m1_hbusreq;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic        m0_hwrite, m1_hwrite;
  logic        m0_hgrant, m1_hgrant;
  logic        s_hready;
  logic [31:0] s_haddr, s_hwdata;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize, s_hburst;
  logic        s_hwrite, hmaster, hmaster_d;

  int n_vec = 0;
  int n_bad = 0;

  ahb_master_arbiter #(.MAX_HOLD(8), .DEFAULT_MASTER(0)) dut (
    .clk(clk), .rst(rst),
    .m0_hbusreq(m0_hbusreq), .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hsize(m0_hsize),
    .m0_hburst(m0_hburst), .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata), .m0_hgrant(m0_hgrant),
    .m1_hbusreq(m1_hbusreq), .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hsize(m1_hsize),
    .m1_hburst(m1_hburst), .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata), .m1_hgrant(m1_hgrant),
    .s_hready(s_hready), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
    .hmaster(hmaster), .hmaster_d(hmaster_d)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       m0r;
    logic       m1r;
    logic       rdy;
    logic       hm;
    logic       hmd;
    logic [7:0] cnt;
    logic [1:0] trans;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input logic [7:0] c);
`ifdef ARB_FIXED_PRIORITY_EN
    return 8'd0;
`else
    return c;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_owner(input string name, input logic hm, input logic hmd);
    chk({name, ".hmaster"}, {31'd0, hmaster}, {31'd0, hm});
    chk({name, ".hmaster_d"}, {31'd0, hmaster_d}, {31'd0, hmd});
    chk({name, ".grants"}, {30'd0, m1_hgrant, m0_hgrant}, {30'd0, hm, ~hm});
  endtask

  initial begin
    rst = 1'b1;
    s_hready = 1'b1;
    m0_hbusreq = 1'b0;          m1_hbusreq = 1'b0;
    m0_haddr   = 32'h1000_0000; m1_haddr   = 32'h0000_0100;
    m0_htrans  = 2'b10;         m1_htrans  = 2'b10;
    m0_hsize   = 3'd2;          m1_hsize   = 3'd1;
    m0_hburst  = 3'd0;          m1_hburst  = 3'd3;
    m0_hwrite  = 1'b0;          m1_hwrite  = 1'b0;
    m0_hwdata  = 32'hAAAA_0000; m1_hwdata  = 32'h5555_1111;

    //             m0r   m1r   rdy   hm    hmd   cnt   trans
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 2'b10};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 2'b10};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 2'b10};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 2'b10};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 2'b10};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 2'b10};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 2'b10};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b10};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b00};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 2'b10};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 2'b00};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b00};

    // Reset state with both requests low: owner M0 but no request, so IDLE on the bus.
    repeat (2) @(posedge clk);
    #1;
    chk_owner("rst_active", 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_owner("rst_release", 1'b0, 1'b0);
    chk("rst_htrans_masked", {30'd0, s_htrans}, 32'd0);
    chk("rst_hold_cnt", {24'd0, dut.hold_cnt_q}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      m0_hbusreq = tbl[i].m0r;
      m1_hbusreq = tbl[i].m1r;
      s_hready   = tbl[i].rdy;
      step();
      chk_owner($sformatf("vec%0d", i), tbl[i].hm, tbl[i].hmd);
      chk($sformatf("vec%0d.hold_cnt", i), {24'd0, dut.hold_cnt_q}, {24'd0, exp_cnt(tbl[i].cnt)});
      chk($sformatf("vec%0d.htrans", i), {30'd0, s_htrans}, {30'd0, tbl[i].trans});
      chk($sformatf("vec%0d.haddr", i), s_haddr, tbl[i].hm ? 32'h0000_0100 : 32'h1000_0000);
      chk($sformatf("vec%0d.hsize", i), {29'd0, s_hsize}, tbl[i].hm ? 32'd1 : 32'd2);
      chk($sformatf("vec%0d.hwdata", i), s_hwdata, tbl[i].hmd ? 32'h5555_1111 : 32'hAAAA_0000);
    end
    s_hready = 1'b1;

    // Contention: M1 owns, M0 joins; M1 holds for MAX_HOLD granted cycles.
    m0_hbusreq = 1'b0; m1_hbusreq = 1'b1;
    step();
    chk_owner("cont_m1_owns", 1'b1, 1'b0);
    m1_htrans = 2'b11;
    m0_htrans = 2'b10;
    m0_hbusreq = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
    step();
    chk("cont_fixed_first_edge", {31'd0, hmaster}, 32'd0);
    chk("cont_fixed_m0_grant", {31'd0, m0_hgrant}, 32'd1);
    chk("cont_fixed_hold_cnt", {24'd0, dut.hold_cnt_q}, 32'd0);
    chk("cont_fixed_htrans", {30'd0, s_htrans}, 32'd2);
`else
    for (int e = 1; e <= 8; e++) begin
      step();
      chk($sformatf("cont_edge%0d.hmaster", e), {31'd0, hmaster}, (e < 8) ? 32'd1 : 32'd0);
      chk($sformatf("cont_edge%0d.hold_cnt", e), {24'd0, dut.hold_cnt_q}, (e < 8) ? e : 32'd0);
    end
    chk("cont_m0_grant", {30'd0, m1_hgrant, m0_hgrant}, 32'd1);
    chk("cont_htrans_owner", {30'd0, s_htrans}, 32'd2);
`endif

    // Stall: M0 owns, M1 requests, s_hready low for three cycles.
    m0_hbusreq = 1'b0; m1_hbusreq = 1'b0;
    m1_htrans = 2'b10;
    step();
    step();
    chk_owner("stall_pre", 1'b0, 1'b0);
    m1_hbusreq = 1'b1;
    s_hready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_owner($sformatf("stall%0d", c), 1'b0, 1'b0);
    end
    s_hready = 1'b1;
    step();
    chk_owner("stall_release", 1'b1, 1'b0);

    // Write handoff: M0 address phase, then M1 granted while M0 write data is in flight.
    m1_hbusreq = 1'b0; m0_hbusreq = 1'b1;
    step();
    m0_haddr = 32'h2000_0000; m0_hwrite = 1'b1; m0_hwdata = 32'hDEAD_BEEF;
    step();
    chk_owner("wr_addr_phase", 1'b0, 1'b0);
    chk("wr_addr", s_haddr, 32'h2000_0000);
    chk("wr_hwrite", {31'd0, s_hwrite}, 32'd1);
    m0_hbusreq = 1'b0; m1_hbusreq = 1'b1;
    step();
    chk_owner("wr_handoff", 1'b1, 1'b0);
    chk("wr_data_from_m0", s_hwdata, 32'hDEAD_BEEF);
    chk("wr_addr_from_m1", s_haddr, 32'h0000_0100);
    chk("wr_hburst_from_m1", {29'd0, s_hburst}, 32'd3);
    step();
    chk("wr_data_from_m1", s_hwdata, 32'h5555_1111);

    // Asynchronous reset while M1 owns mid-transfer.
    #2;
    rst = 1'b1;
    #1;
    chk_owner("async_rst", 1'b0, 1'b0);
    step();
    rst = 1'b0;
    m1_hbusreq = 1'b0;
    step();
    chk_owner("async_rst_release", 1'b0, 1'b0);
    chk("async_rst_hold_cnt", {24'd0, dut.hold_cnt_q}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
